// File: rtl/frag_pkg.sv
// Shared definitions for the LSU: control-word field positions,
// load/store funct3 encodings and the LSU state type.
package frag_pkg;

   localparam int CTRL_W            = 21;
   localparam int CTRL_MEMREAD      = 11;
   localparam int CTRL_LOADTYPE_HI  = 10;
   localparam int CTRL_LOADTYPE_LO  = 8;
   localparam int CTRL_MEMWRITE     = 7;
   localparam int CTRL_STORETYPE_HI = 6;
   localparam int CTRL_STORETYPE_LO = 4;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2,
      DONE = 2'd3
   } lsu_state_t;

   // True for the five load encodings RV32I defines.
   function automatic logic legal_load(input logic [2:0] f3);
      return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
             (f3 == F3_LBU) || (f3 == F3_LHU);
   endfunction

   // True for the three store encodings RV32I defines.
   function automatic logic legal_store(input logic [2:0] f3);
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
   endfunction

endpackage

// File: rtl/frag_lsu_align.sv
// Byte-lane helper: store byte enables and lane replication, access
// legality check, and load-side shift plus sign/zero extension.
// Purely combinational so the fetch path can reuse it later.
module frag_lsu_align
   import frag_pkg::*;
(
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  load_type,
   input  logic [2:0]  store_type,
   input  logic [1:0]  offset,
   input  logic [31:0] store_data,
   output logic [3:0]  be,
   output logic [31:0] store_lanes,
   output logic        err,
   input  logic [2:0]  resp_type,
   input  logic [1:0]  resp_offset,
   input  logic [31:0] resp_word,
   output logic [31:0] load_data
);

   logic [1:0]  size;
   logic        misaligned;
   logic [31:0] shifted;

   // Access size comes from funct3[1:0] for both loads and stores.
   assign size = is_load ? load_type[1:0] : store_type[1:0];

   // Byte enables, store lane replication and legality of the access.
   always_comb begin
      be          = 4'b1111;
      store_lanes = store_data;
      misaligned  = 1'b0;
      case (size)
         2'b00: be = 4'b0001 << offset;
         2'b01: begin
            be         = offset[1] ? 4'b1100 : 4'b0011;
            misaligned = offset[0];
         end
         default: begin
            be         = 4'b1111;
            misaligned = (offset != 2'b00);
         end
      endcase
      case (store_type)
         F3_SB:   store_lanes = {4{store_data[7:0]}};
         F3_SH:   store_lanes = {2{store_data[15:0]}};
         default: store_lanes = store_data;
      endcase
      err = (is_load && is_store) ||
            (is_load && !legal_load(load_type)) ||
            (is_store && !legal_store(store_type)) ||
            misaligned;
   end

   // Move the addressed field down to bit 0 and extend it to 32 bits.
   always_comb begin
      shifted = resp_word >> {resp_offset, 3'b000};
      case (resp_type)
         F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
         F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
         F3_LBU:  load_data = {24'h0, shifted[7:0]};
         F3_LHU:  load_data = {16'h0, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

endmodule

// File: rtl/frag_lsu.sv
// EX/MEM load/store unit: one data-memory transaction per memory
// instruction over req/gnt/rvalid, stalling the pipeline until done.
module frag_lsu
   import frag_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_i,
   input  logic [20:0]       ctrl_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic              stall_o,
   output logic              done_o,
   output logic              err_o,
   output logic [31:0]       rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [3:0]        mem_be_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [31:0]       mem_rdata_i
);

   lsu_state_t        state, state_nxt;

   logic              mem_read, mem_write, mem_op, accept;
   logic [2:0]        load_type, store_type;
   logic [3:0]        be_c;
   logic [31:0]       lanes_c, load_ext;
   logic              err_c;

   logic              is_load_r, err_r;
   logic [2:0]        load_type_r;
   logic [1:0]        offset_r;
   logic [ADDR_W-1:0] addr_r;
   logic [3:0]        be_r;
   logic [31:0]       wdata_r, rdata_r;

   logic              unused_ctrl;

   assign mem_read    = ctrl_i[CTRL_MEMREAD];
   assign mem_write   = ctrl_i[CTRL_MEMWRITE];
   assign load_type   = ctrl_i[CTRL_LOADTYPE_HI:CTRL_LOADTYPE_LO];
   assign store_type  = ctrl_i[CTRL_STORETYPE_HI:CTRL_STORETYPE_LO];
   assign mem_op      = valid_i && (mem_read || mem_write);
   assign accept      = (state == IDLE) && mem_op;
   assign unused_ctrl = ^{ctrl_i[20:12], ctrl_i[3:0]};

   frag_lsu_align u_align (
      .is_load     (mem_read),
      .is_store    (mem_write),
      .load_type   (load_type),
      .store_type  (store_type),
      .offset      (addr_i[1:0]),
      .store_data  (wdata_i),
      .be          (be_c),
      .store_lanes (lanes_c),
      .err         (err_c),
      .resp_type   (load_type_r),
      .resp_offset (offset_r),
      .resp_word   (mem_rdata_i),
      .load_data   (load_ext)
   );

   // State register; reset aborts any access in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Capture the access on accept and the extended load data on rvalid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_load_r   <= 1'b0;
         err_r       <= 1'b0;
         load_type_r <= 3'b000;
         offset_r    <= 2'b00;
         addr_r      <= '0;
         be_r        <= 4'b0000;
         wdata_r     <= 32'h0;
         rdata_r     <= 32'h0;
      end else begin
         if (accept) begin
            is_load_r   <= mem_read;
            err_r       <= err_c;
            load_type_r <= load_type;
            offset_r    <= addr_i[1:0];
            addr_r      <= {addr_i[ADDR_W-1:2], 2'b00};
            be_r        <= be_c;
            wdata_r     <= mem_write ? lanes_c : 32'h0;
         end
         if ((state == RESP) && mem_rvalid_i) begin
            rdata_r <= load_ext;
         end
      end
   end

   // Next state plus all handshake outputs; bus fields are zero outside REQ.
   always_comb begin
      state_nxt   = state;
      stall_o     = 1'b0;
      done_o      = 1'b0;
      err_o       = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_be_o    = 4'b0000;
      mem_addr_o  = '0;
      mem_wdata_o = 32'h0;
      case (state)
         IDLE: begin
            if (mem_op) begin
               stall_o   = 1'b1;
               state_nxt = err_c ? DONE : REQ;
            end
         end
         REQ: begin
            stall_o     = 1'b1;
            mem_req_o   = 1'b1;
            mem_we_o    = !is_load_r;
            mem_be_o    = be_r;
            mem_addr_o  = addr_r;
            mem_wdata_o = wdata_r;
            if (mem_gnt_i) state_nxt = is_load_r ? RESP : DONE;
         end
         RESP: begin
            stall_o = 1'b1;
            if (mem_rvalid_i) state_nxt = DONE;
         end
         DONE: begin
            done_o    = 1'b1;
            err_o     = err_r;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign rdata_o = rdata_r;

endmodule

// File: tb/tb_frag_lsu.sv
// Self-checking bench for frag_lsu: a scoreboard queue holds the expected
// outcome of each instruction, popped when the LSU signals done.
module tb_frag_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_i;
   logic [20:0] ctrl_i;
   logic [31:0] addr_i, wdata_i;
   logic        stall_o, done_o, err_o;
   logic [31:0] rdata_o;
   logic        mem_req_o, mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic        mem_gnt_i, mem_rvalid_i;
   logic [31:0] mem_rdata_i;

   typedef struct {
      logic        err;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        chk_rdata;
      int          latency;
   } exp_t;

   exp_t expQ[$];
   int   testsRun    = 0;
   int   testsFailed = 0;

   frag_lsu #(.ADDR_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .valid_i      (valid_i),
      .ctrl_i       (ctrl_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .stall_o      (stall_o),
      .done_o       (done_o),
      .err_o        (err_o),
      .rdata_o      (rdata_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_be_o     (mem_be_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i)
   );

   always #5 clk = ~clk;

   // The memory side must never grant and return data in the same cycle.
   always @(posedge clk) begin
      if (rst_n) begin
         assert (!(mem_gnt_i && mem_rvalid_i))
            else $error("[TB] protocol violation: gnt and rvalid together");
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [20:0] mkCtrl(input logic mr, input logic [2:0] lt,
                                          input logic mw, input logic [2:0] st);
      logic [20:0] c;
      c       = 21'h1AB00F;
      c[11]   = mr;
      c[10:8] = lt;
      c[7]    = mw;
      c[6:4]  = st;
      return c;
   endfunction

   // Drive one instruction, push its expected outcome, play the memory and
   // pop/compare when done_o arrives. Called at a negedge with the LSU idle.
   task automatic applyStimulus(input string name, input logic [20:0] ctrl,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input int gntDelay, input int rvDelay,
                                input logic [31:0] rdWord, input logic expErr,
                                input logic [3:0] expBe, input logic [31:0] expAddr,
                                input logic [31:0] expWdata, input logic [31:0] expRdata);
      exp_t e, p;
      int   cyc, reqCycles, gntCyc;
      logic doneSeen;
      e.err       = expErr;
      e.we        = ctrl[7];
      e.be        = expBe;
      e.addr      = expAddr;
      e.wdata     = expWdata;
      e.rdata     = expRdata;
      e.chk_rdata = ctrl[11] && !expErr;
      e.latency   = expErr ? 1 : (ctrl[7] ? 2 + gntDelay : 3 + gntDelay + rvDelay);
      expQ.push_back(e);

      valid_i = 1'b1;
      ctrl_i  = ctrl;
      addr_i  = addr;
      wdata_i = wd;
      #1;
      cyc = 0; reqCycles = 0; gntCyc = -1; doneSeen = 1'b0;
      while (!doneSeen && cyc < 40) begin
         if (cyc == 0) checkOutput({name, "_stall_accept"}, {31'h0, stall_o}, 32'h1);
         mem_gnt_i    = 1'b0;
         mem_rvalid_i = 1'b0;
         mem_rdata_i  = $urandom;
         if (done_o) begin
            p = expQ.pop_front();
            checkOutput({name, "_latency"}, cyc, p.latency);
            checkOutput({name, "_err"}, {31'h0, err_o}, {31'h0, p.err});
            checkOutput({name, "_stall_done"}, {31'h0, stall_o}, 32'h0);
            checkOutput({name, "_be_idle"}, {28'h0, mem_be_o}, 32'h0);
            if (p.err) checkOutput({name, "_no_req"}, reqCycles, 0);
            if (p.chk_rdata) checkOutput({name, "_rdata"}, rdata_o, p.rdata);
            valid_i  = 1'b0;
            doneSeen = 1'b1;
         end else begin
            if (mem_req_o) begin
               reqCycles++;
               if (reqCycles == 1) checkOutput({name, "_req_start"}, cyc, 1);
               checkOutput({name, "_addr"}, mem_addr_o, e.addr);
               checkOutput({name, "_be"}, {28'h0, mem_be_o}, {28'h0, e.be});
               checkOutput({name, "_we"}, {31'h0, mem_we_o}, {31'h0, e.we});
               if (e.we) checkOutput({name, "_wdata"}, mem_wdata_o, e.wdata);
               checkOutput({name, "_stall_req"}, {31'h0, stall_o}, 32'h1);
               if (reqCycles > gntDelay) begin
                  mem_gnt_i = 1'b1;
                  gntCyc    = cyc;
               end
            end
            if (gntCyc >= 0 && cyc == gntCyc + 1 + rvDelay) begin
               mem_rvalid_i = 1'b1;
               mem_rdata_i  = rdWord;
            end
            @(negedge clk); #1;
            cyc++;
         end
      end
      if (!doneSeen) begin
         checkOutput({name, "_timeout"}, 32'h0, 32'h1);
         void'(expQ.pop_front());
         valid_i = 1'b0;
      end
      @(negedge clk); #1;
      checkOutput({name, "_idle_after"}, {31'h0, stall_o}, 32'h0);
   endtask

   // Abort a load with reset while in REQ or RESP, then send a stray rvalid.
   task automatic resetDuring(input string name, input logic inResp);
      valid_i = 1'b1;
      ctrl_i  = mkCtrl(1'b1, 3'b010, 1'b0, 3'b000);
      addr_i  = 32'h600;
      wdata_i = 32'h0;
      @(negedge clk); #1;
      checkOutput({name, "_req_before"}, {31'h0, mem_req_o}, 32'h1);
      if (inResp) begin
         mem_gnt_i = 1'b1;
         @(negedge clk); #1;
         mem_gnt_i = 1'b0;
         checkOutput({name, "_resp_stall"}, {31'h0, stall_o}, 32'h1);
      end
      valid_i = 1'b0;
      rst_n   = 1'b0;
      #1;
      checkOutput({name, "_req_drop"}, {31'h0, mem_req_o}, 32'h0);
      checkOutput({name, "_stall_drop"}, {31'h0, stall_o}, 32'h0);
      @(negedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk); #1;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hCAFEF00D;
      @(negedge clk); #1;
      mem_rvalid_i = 1'b0;
      checkOutput({name, "_late_done"}, {31'h0, done_o}, 32'h0);
      checkOutput({name, "_late_rdata"}, rdata_o, 32'h0);
      @(negedge clk); #1;
   endtask

   initial begin
      rst_n        = 1'b0;
      valid_i      = 1'b0;
      ctrl_i       = 21'h0;
      addr_i       = 32'h0;
      wdata_i      = 32'h0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'h0;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("rst_req", {31'h0, mem_req_o}, 32'h0);
      checkOutput("rst_we", {31'h0, mem_we_o}, 32'h0);
      checkOutput("rst_be", {28'h0, mem_be_o}, 32'h0);
      checkOutput("rst_addr", mem_addr_o, 32'h0);
      checkOutput("rst_wdata", mem_wdata_o, 32'h0);
      checkOutput("rst_done", {31'h0, done_o}, 32'h0);
      checkOutput("rst_err", {31'h0, err_o}, 32'h0);
      checkOutput("rst_rdata", rdata_o, 32'h0);
      checkOutput("rst_stall", {31'h0, stall_o}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk); #1;

      applyStimulus("sw", mkCtrl(0, 3'b000, 1, 3'b010), 32'h100, 32'hDEADBEEF, 0, 0, 32'h0,
                    0, 4'b1111, 32'h100, 32'hDEADBEEF, 32'h0);
      applyStimulus("sb", mkCtrl(0, 3'b000, 1, 3'b000), 32'h203, 32'h000000A5, 3, 0, 32'h0,
                    0, 4'b1000, 32'h200, 32'hA5A5A5A5, 32'h0);
      applyStimulus("lb", mkCtrl(1, 3'b000, 0, 3'b000), 32'h301, 32'h0, 0, 0, 32'h00008000,
                    0, 4'b0010, 32'h300, 32'h0, 32'hFFFFFF80);
      applyStimulus("lbu", mkCtrl(1, 3'b100, 0, 3'b000), 32'h301, 32'h0, 0, 0, 32'h00008000,
                    0, 4'b0010, 32'h300, 32'h0, 32'h00000080);
      applyStimulus("lh", mkCtrl(1, 3'b001, 0, 3'b000), 32'h402, 32'h0, 0, 0, 32'h80010000,
                    0, 4'b1100, 32'h400, 32'h0, 32'hFFFF8001);
      applyStimulus("lw_slow", mkCtrl(1, 3'b010, 0, 3'b000), 32'h500, 32'h0, 1, 3, 32'h12345678,
                    0, 4'b1111, 32'h500, 32'h0, 32'h12345678);
      applyStimulus("lhu", mkCtrl(1, 3'b101, 0, 3'b000), 32'h002, 32'h0, 0, 0, 32'hF00D1234,
                    0, 4'b1100, 32'h000, 32'h0, 32'h0000F00D);
      applyStimulus("sh", mkCtrl(0, 3'b000, 1, 3'b001), 32'h006, 32'h1234BEEF, 1, 0, 32'h0,
                    0, 4'b1100, 32'h004, 32'hBEEFBEEF, 32'h0);
      applyStimulus("sb_lane0", mkCtrl(0, 3'b000, 1, 3'b000), 32'h010, 32'hFFFFFF3C, 0, 0, 32'h0,
                    0, 4'b0001, 32'h010, 32'h3C3C3C3C, 32'h0);
      applyStimulus("lw_mis", mkCtrl(1, 3'b010, 0, 3'b000), 32'h101, 32'h0, 0, 0, 32'h0,
                    1, 4'b0000, 32'h0, 32'h0, 32'h0);
      applyStimulus("lt_011", mkCtrl(1, 3'b011, 0, 3'b000), 32'h100, 32'h0, 0, 0, 32'h0,
                    1, 4'b0000, 32'h0, 32'h0, 32'h0);
      applyStimulus("rd_wr", mkCtrl(1, 3'b010, 1, 3'b010), 32'h100, 32'h0, 0, 0, 32'h0,
                    1, 4'b0000, 32'h0, 32'h0, 32'h0);
      applyStimulus("sh_mis", mkCtrl(0, 3'b000, 1, 3'b001), 32'h001, 32'h0, 0, 0, 32'h0,
                    1, 4'b0000, 32'h0, 32'h0, 32'h0);
      applyStimulus("st_011", mkCtrl(0, 3'b000, 1, 3'b011), 32'h100, 32'h0, 0, 0, 32'h0,
                    1, 4'b0000, 32'h0, 32'h0, 32'h0);

      valid_i = 1'b1;
      ctrl_i  = mkCtrl(0, 3'b010, 0, 3'b010);
      addr_i  = 32'h101;
      for (int i = 0; i < 3; i++) begin
         #1;
         checkOutput("nonmem_stall", {31'h0, stall_o}, 32'h0);
         checkOutput("nonmem_req", {31'h0, mem_req_o}, 32'h0);
         checkOutput("nonmem_done", {31'h0, done_o}, 32'h0);
         @(negedge clk);
      end
      valid_i = 1'b0;
      #1;

      resetDuring("rst_in_req", 1'b0);
      resetDuring("rst_in_resp", 1'b1);
      applyStimulus("sw_after_rst", mkCtrl(0, 3'b000, 1, 3'b010), 32'h700, 32'h0BADF00D, 0, 0,
                    32'h0, 0, 4'b1111, 32'h700, 32'h0BADF00D, 32'h0);

      checkOutput("queue_empty", expQ.size(), 0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/frag_lsu.md
Name: frag_lsu

Overview:
- Load/store unit that consumes the memory fields of the 21-bit control word produced by the instruction decoder: MemRead, LoadType, MemWrite and StoreType.
- Executes one data-memory transaction per memory instruction over a req/gnt/rvalid handshake.
- Generates byte enables and lane-replicated store data. Sign- or zero-extends load data.
- Stalls the pipeline until the access completes.
- Sits in the EX/MEM stage between the ALU result (address) and the data-memory port.

Parameters:
- ADDR_W, 32, width of the byte address and the memory address bus (data width fixed at 32, RV32).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- valid_i  in  1  instruction in stage is valid; ctrl_i, addr_i and wdata_i are stable while stall_o=1
- ctrl_i  in  21  decoder control word. Fields used:
  - MemRead = bit 11
  - LoadType = bits 10:8
  - MemWrite = bit 7
  - StoreType = bits 6:4
  - all other bits ignored
- addr_i  in  ADDR_W  byte address (ALU result)
- wdata_i  in  32  store data (rs2)
- stall_o  out  1  hold the pipeline
- done_o  out  1  one-cycle pulse; access finished (or was rejected)
- err_o  out  1  valid with done_o; misaligned or illegal access
- rdata_o  out  32  extended load result; valid with done_o, held until the next done_o
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1 = write
- mem_be_o  out  4  byte enables
- mem_addr_o  out  ADDR_W  word-aligned address: {addr[ADDR_W-1:2], 2'b00}
- mem_wdata_o  out  32  lane-replicated store data
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  read data valid, earliest one cycle after gnt
- mem_rdata_i  in  32  read word

Behaviour:
- Reset (async, immediate):
  - FSM goes to IDLE.
  - mem_req_o, mem_we_o, done_o and err_o are 0.
  - mem_be_o, mem_addr_o, mem_wdata_o and rdata_o are 0.
  - A reset mid-transaction drops mem_req_o immediately. A late rvalid after reset is ignored.
- Memory op:
  - A memory op is valid_i & (MemRead | MemWrite).
  - Non-memory instructions are ignored and never stall.
- Accept (IDLE, memory op present):
  - Register the type, the address, the extended store data and the byte enables.
  - stall_o=1 combinationally in this cycle.
- Error check at accept (no memory request is issued on error):
  - MemRead & MemWrite both set.
  - LoadType not in {000, 001, 010, 100, 101}.
  - StoreType not in {000, 001, 010}.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠00.
  - On error: IDLE→DONE with err_o=1.
- States:
  - IDLE: no request. Accept → REQ, or → DONE on error.
  - REQ: mem_req_o=1, with we/be/addr/wdata stable, until mem_gnt_i. On gnt, store → DONE, load → RESP.
  - RESP: wait for mem_rvalid_i. On rvalid, latch the extended data into rdata_o and go → DONE.
  - DONE: done_o=1 (err_o as recorded) for exactly one cycle; stall_o=0; then → IDLE.
- stall_o = (IDLE & memory op) | REQ | RESP. In DONE the pipeline advances.
  - The next instruction can be accepted in the cycle after DONE, so there are no back-to-back accepts without an IDLE cycle.
- Minimum latency:
  - Store with immediate gnt: done_o 2 cycles after accept.
  - Load with gnt in REQ and rvalid in the next cycle: done_o 3 cycles after accept.
- Unbounded gnt/rvalid waits are legal. There is no timeout.
- Store lanes (o = addr[1:0]):
  - SB: be = 4'b0001<<o; wdata = {4{b}}.
  - SH: be = addr[1] ? 1100 : 0011; wdata = {2{h}}.
  - SW: be = 1111; wdata = rs2.
- Loads:
  - mem_be_o is computed the same way as for stores.
  - Field = mem_rdata_i >> (8*o).
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- mem_we_o, mem_be_o, mem_addr_o and mem_wdata_o return to 0 outside REQ.
- rvalid outside RESP is ignored.
- gnt and rvalid in the same cycle within REQ: rvalid is ignored. A protocol violation is flagged by an assertion in the bench.

Decomposition:
- Shared package frag_pkg:
  - ctrl-word bit positions (CTRL_MEMREAD=11, CTRL_LOADTYPE_HI/LO=10/8, CTRL_MEMWRITE=7, CTRL_STORETYPE_HI/LO=6/4).
  - funct3 load/store encodings (LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010).
  - lsu_state_t enum {IDLE, REQ, RESP, DONE}.
- One combinational sub-module, frag_lsu_align:
  - store-side byte enables and lane replication.
  - load-side shift and extend.
  - misalignment/illegal check.
  - It is reused by the future instruction-fetch path.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt immediate → req with be=1111, addr=0x100, data=0xDEADBEEF; done_o at accept+2; err_o=0.
- SB addr=0x203, rs2=0x000000A5 → be=1000, addr=0x200, wdata=0xA5A5A5A5; gnt delayed 3 cycles → req held stable, stall_o=1 throughout, done at accept+5.
- LB and LBU addr=0x301, mem_rdata=0x00008000 → LB rdata_o=0xFFFFFF80, LBU rdata_o=0x00000080.
- LH addr=0x402, mem_rdata=0x80010000 → rdata_o=0xFFFF8001. LW with rvalid 4 cycles after gnt → done one cycle after rvalid.
- LW addr=0x101 → no mem_req_o ever; done_o=1, err_o=1 at accept+1. The same applies to LoadType=011 and to MemRead=MemWrite=1.
- Assert rst_n low while in REQ and while in RESP → mem_req_o drops in the same cycle. A subsequent rvalid is ignored; the next SW completes normally.
